// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
//   Tracks the destination register of every instruction in the DEPTH stages
//   after decode. From that record it forms the decode stall, the IF/ID flush
//   and the forwarding selects for both source operands.
//   Optional feature macro: SCB_PERF_CNT_EN adds saturating stall/flush
//   counters. Without it both counter ports read as zero.
module pipe_hazard_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int RDY_ALU = 2,
    parameter int RDY_LD  = 3,
    parameter int RA_W    = 5,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              redirect,
    output logic              stall,
    output logic              pc_ld,
    output logic              if_id_write,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_rs_sel,
    output logic [SEL_W-1:0]  fwd_rt_sel,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);

    // Index k of each array is pipeline stage k (1 = EX, DEPTH = WB).
    logic            ent_valid [1:DEPTH];
    logic [RA_W-1:0] ent_rd    [1:DEPTH];
    logic            ent_rw    [1:DEPTH];
    logic            ent_ld    [1:DEPTH];

    // Result of a source lookup: MSB = not-yet-ready hazard, LSBs = select.
    logic [SEL_W:0]  rs_res;
    logic [SEL_W:0]  rt_res;

    // Scans stages oldest to youngest, so the last hit kept is the youngest.
    function automatic logic [SEL_W:0] resolve(input logic [RA_W-1:0] src,
                                               input logic            used);
        logic [SEL_W:0] res;
        res = '0;
        if (used && src != '0) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (ent_valid[k] && ent_rw[k] && ent_rd[k] == src) begin
                    if (k >= (ent_ld[k] ? RDY_LD : RDY_ALU))
                        res = {1'b0, SEL_W'(k)};
                    else
                        res = {1'b1, {SEL_W{1'b0}}};
                end
            end
        end
        return res;
    endfunction

    // Zero-latency hazard detection from the current entries and decode slot.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missing
        // default here would silently infer a latch.
        rs_res = resolve(id_rs, id_rs_used);
        rt_res = resolve(id_rt, id_rt_used);
    end

    assign stall       = id_valid & (rs_res[SEL_W] | rt_res[SEL_W]);
    assign pc_ld       = ~stall;
    assign if_id_write = ~stall;
    // A redirect under a stall is dropped; the held branch re-raises it later.
    assign flush       = redirect & ~stall;
    assign fwd_rs_sel  = rs_res[SEL_W-1:0];
    assign fwd_rt_sel  = rt_res[SEL_W-1:0];

    // Valid bits: shift down the pipe, bubble into stage 1 on a stall.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every stage
        // samples its neighbour's pre-edge value.
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) ent_valid[k] <= 1'b0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) ent_valid[k] <= ent_valid[k-1];
            ent_valid[1] <= id_valid & ~stall;
        end
    end

    // Payload fields: shift every cycle and are only looked at when valid.
    always_ff @(posedge clk) begin
        // NOTE: payload is deliberately not reset; the cleared valid bits
        // already make stale contents invisible.
        for (int k = DEPTH; k >= 2; k--) begin
            ent_rd[k] <= ent_rd[k-1];
            ent_rw[k] <= ent_rw[k-1];
            ent_ld[k] <= ent_ld[k-1];
        end
        ent_rd[1] <= id_rd;
        ent_rw[1] <= id_reg_write;
        ent_ld[1] <= id_mem_read;
    end

`ifdef SCB_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters; reset wins over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard
//   Directed bench for pipe_hazard_scoreboard. A queue-based model of the
//   instructions in flight predicts stall, flush, selects and counters on
//   every cycle; literal expectations pin the key scenarios, including a
//   second instance with DEPTH=5, RDY_LD=4.
module tb_pipe_hazard_scoreboard;

    localparam int M_DEPTH   = 3;
    localparam int M_RDY_ALU = 2;
    localparam int M_RDY_LD  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_rs_used, id_rt_used, id_reg_write, id_mem_read, redirect;

    logic        stall, pc_ld, if_id_write, flush;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt, flush_cnt;

    logic        stall5, pc_ld5, if_id_write5, flush5;
    logic [2:0]  fwd_rs_sel5, fwd_rt_sel5;
    logic [31:0] stall_cnt5, flush_cnt5;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(.DEPTH(M_DEPTH), .RDY_ALU(M_RDY_ALU), .RDY_LD(M_RDY_LD), .RA_W(5)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
        .stall(stall), .pc_ld(pc_ld), .if_id_write(if_id_write), .flush(flush),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_scoreboard #(.DEPTH(5), .RDY_ALU(2), .RDY_LD(4), .RA_W(5)) u_dut5 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .redirect(redirect),
        .stall(stall5), .pc_ld(pc_ld5), .if_id_write(if_id_write5), .flush(flush5),
        .fwd_rs_sel(fwd_rs_sel5), .fwd_rt_sel(fwd_rt_sel5),
        .stall_cnt(stall_cnt5), .flush_cnt(flush_cnt5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } rec_t;

    rec_t  hist[$];     // hist[0] is the instruction that entered stage 1 last
    int    m_stall_cnt = 0;
    int    m_flush_cnt = 0;

    // Youngest in-flight writer of s decides: ready -> its stage, else hazard.
    function automatic void model_src(input logic [4:0] s, input logic used,
                                      output int sel, output bit hz);
        int need;
        sel = 0;
        hz  = 1'b0;
        if (!used || s == 5'd0) return;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].v && hist[i].rw && hist[i].rd == s) begin
                need = hist[i].ld ? M_RDY_LD : M_RDY_ALU;
                if (i + 1 >= need) sel = i + 1;
                else               hz  = 1'b1;
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        int s1, s2;
        bit h1, h2;
        model_src(id_rs, id_rs_used, s1, h1);
        model_src(id_rt, id_rt_used, s2, h2);
        return id_valid && (h1 || h2);
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk) begin
        rec_t r;
        bit   st;
        if (rst) begin
            hist.delete();
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            st = model_stall();
            if (st) m_stall_cnt++;
            if (redirect && !st) m_flush_cnt++;
            r.v  = id_valid && !st;
            r.rd = id_rd;
            r.rw = id_reg_write;
            r.ld = id_mem_read;
            hist.push_front(r);
            if (hist.size() > M_DEPTH) void'(hist.pop_back());
        end
    end

    // Compare process: every falling edge once out of the initial reset.
    always @(negedge clk) begin
        int s1, s2;
        bit h1, h2, st;
        if (checking) begin
            model_src(id_rs, id_rs_used, s1, h1);
            model_src(id_rt, id_rt_used, s2, h2);
            st = id_valid && (h1 || h2);
            check("stall",       {31'd0, stall},       {31'd0, st});
            check("pc_ld",       {31'd0, pc_ld},       {31'd0, !st});
            check("if_id_write", {31'd0, if_id_write}, {31'd0, !st});
            check("flush",       {31'd0, flush},       {31'd0, redirect && !st});
            if (!h1) check("fwd_rs_sel", {30'd0, fwd_rs_sel}, s1);
            if (!h2) check("fwd_rt_sel", {30'd0, fwd_rt_sel}, s2);
`ifdef SCB_PERF_CNT_EN
            check("stall_cnt", stall_cnt, m_stall_cnt);
            check("flush_cnt", flush_cnt, m_flush_cnt);
`else
            check("stall_cnt", stall_cnt, 32'd0);
            check("flush_cnt", flush_cnt, 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu,
                         input logic [4:0] rd, input logic rw, input logic ld,
                         input logic redir);
        id_valid     = v;
        id_rs        = rs;
        id_rs_used   = rsu;
        id_rt        = rt;
        id_rt_used   = rtu;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = ld;
        redirect     = redir;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;

        // Reset state: empty pipe, flush follows redirect.
        drive(1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("pin_rst_stall", {31'd0, stall}, 32'd0);
        check("pin_rst_flush", {31'd0, flush}, 32'd1);
        check("pin_rst_sel",   {30'd0, fwd_rs_sel}, 32'd0);
        step();

        // Back-to-back ALU: add r3, then read r3.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pin_alu_stall1", {31'd0, stall}, 32'd1);
        step();
        @(negedge clk);
        check("pin_alu_stall2", {31'd0, stall}, 32'd0);
        check("pin_alu_sel",    {30'd0, fwd_rs_sel}, 32'd2);
        step();

        // Load-use: lw r5, then read r5 via rt. DEPTH=3 stalls 2, DEPTH=5 stalls 3.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pin_ld_c1",  {31'd0, stall},  32'd1);
        check("pin_ld5_c1", {31'd0, stall5}, 32'd1);
        step();
        @(negedge clk);
        check("pin_ld_c2",  {31'd0, stall},  32'd1);
        check("pin_ld5_c2", {31'd0, stall5}, 32'd1);
        step();
        @(negedge clk);
        check("pin_ld_c3",     {31'd0, stall},      32'd0);
        check("pin_ld_sel",    {30'd0, fwd_rt_sel}, 32'd3);
        check("pin_ld5_c3",    {31'd0, stall5},     32'd1);
        step();
        @(negedge clk);
        check("pin_ld5_c4",  {31'd0, stall5},      32'd0);
        check("pin_ld5_sel", {29'd0, fwd_rt_sel5}, 32'd4);
        step();

        // Youngest wins: two writers of r4, then an unrelated instruction.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pin_young_sel",   {30'd0, fwd_rs_sel}, 32'd2);
        check("pin_young_stall", {31'd0, stall}, 32'd0);
        step();

        // Register 0 never matches, even with fresh writers of r0.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pin_r0_stall", {31'd0, stall}, 32'd0);
        check("pin_r0_rs",    {30'd0, fwd_rs_sel}, 32'd0);
        check("pin_r0_rt",    {30'd0, fwd_rt_sel}, 32'd0);
        step();

        // Redirect during a load-use stall, counters from a clean reset.
        rst = 1'b1;
        nop();
        step();
        rst = 1'b0;
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("pin_rd_flush1", {31'd0, flush}, 32'd0);
        step();
        @(negedge clk);
        check("pin_rd_flush2", {31'd0, flush}, 32'd0);
        step();
        @(negedge clk);
        check("pin_rd_stall3", {31'd0, stall}, 32'd0);
        check("pin_rd_flush3", {31'd0, flush}, 32'd1);
        step();
        nop();
        @(negedge clk);
`ifdef SCB_PERF_CNT_EN
        check("pin_flush_cnt", flush_cnt, 32'd1);
        check("pin_stall_cnt", stall_cnt, 32'd2);
`else
        check("pin_flush_cnt", flush_cnt, 32'd0);
        check("pin_stall_cnt", stall_cnt, 32'd0);
`endif
        step();

        // Reset in the middle of a load-use stall.
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pin_mid_pre", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("pin_mid_stall",  {31'd0, stall},       32'd0);
        check("pin_mid_sel",    {30'd0, fwd_rt_sel},  32'd0);
        check("pin_mid_stall5", {31'd0, stall5},      32'd0);
        check("pin_mid_sel5",   {29'd0, fwd_rt_sel5}, 32'd0);
        step();

        // Mixed traffic over a small register set, checked by the model.
        for (int i = 0; i < 80; i++) begin
            drive($urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
            step();
        end

        nop();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_scoreboard.md
PIPE_HAZARD_SCOREBOARD -- requirements
Module: pipe_hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, number of tracked stages after decode (stage 1 = EX, stage DEPTH = WB); legal range 2..8.
REQ-002 Parameter RDY_ALU, default 2, lowest stage index at which a non-load result is forwardable; legal range 1..DEPTH.
REQ-003 Parameter RDY_LD, default 3, lowest stage index at which a load result is forwardable; legal range RDY_ALU..DEPTH.
REQ-004 Parameter RA_W, default 5, register address width.
REQ-005 Derived SEL_W = $clog2(DEPTH+1).
REQ-006 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 id_valid  in  1  decode slot holds a real instruction.
REQ-010 id_rs, id_rt  in  RA_W each  decode source registers.
REQ-011 id_rs_used, id_rt_used  in  1 each  source actually read.
REQ-012 id_rd  in  RA_W  decode destination register after RegDst selection.
REQ-013 id_reg_write, id_mem_read  in  1 each  decode instruction writes a register / is a load.
REQ-014 redirect  in  1  branch taken or jump resolved in decode.
REQ-015 stall  out  1  hold PC and IF/ID, insert bubble into stage 1.
REQ-016 pc_ld, if_id_write  out  1 each  load enables, equal to ~stall.
REQ-017 flush  out  1  clear IF/ID on the next edge.
REQ-018 fwd_rs_sel, fwd_rt_sel  out  SEL_W each  0 = register file, k = result of stage k.
REQ-019 stall_cnt, flush_cnt  out  32 each  performance counters (REQ-033).

Function
REQ-020 The block SHALL hold DEPTH entries {valid, rd, rw, ld}; on each edge entry k+1 takes entry k, and the entry leaving stage DEPTH is discarded.
REQ-021 Entry 1 SHALL load {id_valid, id_rd, id_reg_write, id_mem_read} when stall=0, and SHALL load valid=0 when stall=1.
REQ-022 An entry matches source s when valid=1, rw=1, rd==s and s!=0; register 0 SHALL never match.
REQ-023 For each used, nonzero source, the youngest matching entry (lowest k) SHALL be selected; older matches are ignored.
REQ-024 The selected entry is ready when k>=RDY_LD (ld=1) or k>=RDY_ALU (ld=0); if ready, fwd_*_sel=k, otherwise stall=1.
REQ-025 With no match, or the source unused, fwd_*_sel SHALL be 0; the register file is write-through, so a retired result needs no forwarding.
REQ-026 stall SHALL be 0 whenever id_valid=0.
REQ-027 Cycle behaviour: stall, flush and the selects SHALL be combinational from the current entries and decode inputs, with zero latency.
REQ-028 flush SHALL equal redirect & ~stall; a redirect seen during a stall is ignored and SHALL be re-evaluated when the stall clears.
REQ-029 The decode instruction that raises redirect SHALL itself enter stage 1 normally (the branch/jump still issues).

Reset
REQ-030 On rst=1 at a clock edge, all entry valid bits and both counters SHALL be cleared.
REQ-031 Consequences of reset: after the edge, stall=0, flush=redirect, and both selects are 0; in-flight entries are discarded when reset is asserted mid-operation.
REQ-032 Reset SHALL take priority over shifting and over counting.

Configuration
REQ-033 Macro SCB_PERF_CNT_EN, when defined: stall_cnt increments on each cycle with stall=1, flush_cnt increments on each cycle with flush=1, and both saturate at 32'hFFFFFFFF.
REQ-034 When SCB_PERF_CNT_EN is undefined: stall_cnt and flush_cnt are present but tied to 0, and no counter flops are generated.

Verification
REQ-035 Back-to-back ALU op, defaults: add r3 issued, then next decode reads r3 -> stall=1 for 1 cycle, then fwd_rs_sel=2, stall=0.
REQ-036 Load-use case: lw r5 issued, then the next instruction reads r5 via rt -> stall=1 for 2 cycles, then fwd_rt_sel=3.
REQ-037 Youngest wins: r4 written by stage 3 and stage 2 entries, decode reads r4 -> fwd_rs_sel=2; decode reads r0 with matching r0 entries -> sel=0, stall=0.
REQ-038 Redirect interplay: redirect=1 while stall=1 -> flush=0; stall clears with redirect still 1 -> flush=1 in the same cycle; with the macro defined, flush_cnt=1.
REQ-039 Reset mid-stream: rst pulsed while a load dependency is stalling -> the next cycle has stall=0 and sel=0; with DEPTH=5, RDY_LD=4 the load-use stall is 3 cycles.
